mnist_frame_sequencer: RTL

//  Controls one MNIST frame from capture to result. Accepts 28 rows of 7 binary pixels over a valid/ready
//  row bus and packs them into a 196-bit image register. When the frame is full it pulses the classifier
//  and waits for its done handshake. It then holds the class result until the next frame is requested.

---
 rtl/mnist_pkg.sv | 19 +
 rtl/mnist_row_packer.sv | 41 ++++
 rtl/mnist_frame_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mnist_pkg.sv
// Shared frame geometry, timing constants and sequencer state type for the MNIST frame path.
package mnist_pkg;

    localparam int ROWS           = 28;
    localparam int COLS           = 7;
    localparam int IMG_W          = ROWS * COLS;
    localparam int CLASS_W        = 4;
    localparam int TIMEOUT_CYCLES = 1023;
    localparam int ROW_CNT_W      = $clog2(ROWS);
    localparam int GAP_W          = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        INFER = 2'd2,
        WAIT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/mnist_row_packer.sv
// Image register for one MNIST frame: places each accepted row at its slot, row 0 in the MSBs.
import mnist_pkg::*;

module mnist_row_packer (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 clear_i,
    input  logic                 wr_en_i,
    input  logic [ROW_CNT_W-1:0] row_idx_i,
    input  logic [COLS-1:0]      row_i,
    output logic [IMG_W-1:0]     image_o
);

    logic [IMG_W-1:0] image_q;
    logic [IMG_W-1:0] image_d;

    // Clear wins over a write so a restart always leaves an empty image.
    always_comb begin
        image_d = image_q;
        if (clear_i) begin
            image_d = '0;
        end else if (wr_en_i) begin
            for (int r = 0; r < ROWS; r++) begin
                if (row_idx_i == ROW_CNT_W'(r)) begin
                    image_d[IMG_W-1-r*COLS -: COLS] = row_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            image_q <= '0;
        end else begin
            image_q <= image_d;
        end
    end

    assign image_o = image_q;

endmodule

// File: rtl/mnist_frame_sequencer.sv
// Frame sequencer: row capture, classifier handshake and result hold for one MNIST frame.
// Optional inter-beat timeout abort is enabled by defining IMG_SEQ_TIMEOUT_EN.
import mnist_pkg::*;

module mnist_frame_sequencer (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_frame_i,
    input  logic               row_valid_i,
    input  logic [COLS-1:0]    row_data_i,
    output logic               row_ready_o,
    output logic [IMG_W-1:0]   image_data_o,
    output logic               image_valid_o,
    output logic               infer_start_o,
    input  logic               infer_done_i,
    input  logic [CLASS_W-1:0] infer_class_i,
    output logic [CLASS_W-1:0] result_class_o,
    output logic               result_valid_o,
    output logic               busy_o,
    output logic               error_o
);

    seq_state_t           state_q, state_d;
    logic [ROW_CNT_W-1:0] row_cnt_q, row_cnt_d;
    logic                 image_valid_q, image_valid_d;
    logic [CLASS_W-1:0]   result_class_q, result_class_d;
    logic                 result_valid_q, result_valid_d;
    logic                 img_clear;
    logic                 img_wr_en;
    logic                 beat_accept;
    logic                 last_row;

`ifdef IMG_SEQ_TIMEOUT_EN
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic                 error_q, error_d;
`endif

    assign beat_accept = row_valid_i && (state_q == LOAD);
    assign last_row    = (row_cnt_q == ROW_CNT_W'(ROWS - 1));

    // Priority inside LOAD: restart, then beat, then timeout abort.
    always_comb begin
        state_d        = state_q;
        row_cnt_d      = row_cnt_q;
        image_valid_d  = image_valid_q;
        result_class_d = result_class_q;
        result_valid_d = result_valid_q;
        img_clear      = 1'b0;
        img_wr_en      = 1'b0;
`ifdef IMG_SEQ_TIMEOUT_EN
        gap_cnt_d      = gap_cnt_q;
        error_d        = error_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_frame_i) begin
                    img_clear      = 1'b1;
                    row_cnt_d      = '0;
                    image_valid_d  = 1'b0;
                    result_valid_d = 1'b0;
`ifdef IMG_SEQ_TIMEOUT_EN
                    gap_cnt_d      = '0;
                    error_d        = 1'b0;
`endif
                    state_d        = LOAD;
                end
            end
            LOAD: begin
                if (start_frame_i) begin
                    img_clear = 1'b1;
                    row_cnt_d = '0;
`ifdef IMG_SEQ_TIMEOUT_EN
                    gap_cnt_d = '0;
`endif
                end else if (beat_accept) begin
                    img_wr_en = 1'b1;
`ifdef IMG_SEQ_TIMEOUT_EN
                    gap_cnt_d = '0;
`endif
                    if (last_row) begin
                        row_cnt_d     = '0;
                        image_valid_d = 1'b1;
                        state_d       = INFER;
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end else begin
`ifdef IMG_SEQ_TIMEOUT_EN
                    if (gap_cnt_q == GAP_W'(TIMEOUT_CYCLES)) begin
                        error_d       = 1'b1;
                        image_valid_d = 1'b0;
                        row_cnt_d     = '0;
                        state_d       = IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
`endif
                end
            end
            INFER: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (infer_done_i) begin
                    result_class_d = infer_class_i;
                    result_valid_d = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            row_cnt_q      <= '0;
            image_valid_q  <= 1'b0;
            result_class_q <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_cnt_q      <= row_cnt_d;
            image_valid_q  <= image_valid_d;
            result_class_q <= result_class_d;
            result_valid_q <= result_valid_d;
        end
    end

`ifdef IMG_SEQ_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            gap_cnt_q <= '0;
            error_q   <= 1'b0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
            error_q   <= error_d;
        end
    end

    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

    mnist_row_packer u_packer (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (img_clear),
        .wr_en_i   (img_wr_en),
        .row_idx_i (row_cnt_q),
        .row_i     (row_data_i),
        .image_o   (image_data_o)
    );

    assign row_ready_o    = (state_q == LOAD);
    assign infer_start_o  = (state_q == INFER);
    assign busy_o         = (state_q != IDLE);
    assign image_valid_o  = image_valid_q;
    assign result_class_o = result_class_q;
    assign result_valid_o = result_valid_q;

endmodule
